dac_spi_tx: RTL and testbench

Serial output stage for the sine generator. Accepts the two phase-offset samples (`dout1`, `dout2`) produced by the sine generator through a valid/ready handshake and shifts them out, one after the other, to an external dual-channel serial DAC. Each sample is sent in its own chip-select frame: SCLK idle low, MSB first, with the DAC sampling on the rising edge. A per-pair completion pulse lets the surrounding logic pace the generator's `en` to the DAC throughput.

---
 rtl/dac_spi_tx.sv | 144 ++++++++++++++
 tb/tb_dac_spi_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Serial DAC transmitter: shifts a captured sample pair out as two
// chip-select frames, MSB first, SCLK idle low, DAC samples on rising SCLK.
module dac_spi_tx #(
  parameter int D_WIDTH = 8,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] sample1,
  input  logic [D_WIDTH-1:0] sample2,
  input  logic               valid,
  output logic               ready,
  output logic               cs_n,
  output logic               sclk,
  output logic               mosi,
  output logic               pair_done
);

  localparam int F  = D_WIDTH + 2;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(F);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(F - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t             state, state_n;
  logic               ch, ch_n;
  logic [DW-1:0]      div, div_n;
  logic [BW-1:0]      bit_idx, bit_n;
  logic [F-1:0]       word, word_n;
  logic [D_WIDTH-1:0] smp2, smp2_n;
  logic               cs_n_n, sclk_n, mosi_n, pair_done_n;
  logic               div_end;

  assign ready   = (state == IDLE) && en;
  assign div_end = (div == DIV_END);

  always_comb begin
    state_n     = state;
    ch_n        = ch;
    div_n       = div;
    bit_n       = bit_idx;
    word_n      = word;
    smp2_n      = smp2;
    cs_n_n      = cs_n;
    sclk_n      = sclk;
    mosi_n      = mosi;
    pair_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        cs_n_n = 1'b1;
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        if (valid && en) begin
          state_n = SHIFT;
          ch_n    = 1'b0;
          div_n   = '0;
          bit_n   = BIT_TOP;
          word_n  = {1'b0, 1'b1, sample1};
          smp2_n  = sample2;
          cs_n_n  = 1'b0;
          mosi_n  = 1'b0;
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          if (!sclk) begin
            sclk_n = 1'b1;
          end else begin
            // End of a bit's high phase: advance data on the falling edge
            sclk_n = 1'b0;
            if (bit_idx == '0) begin
              state_n = HOLD;
            end else begin
              bit_n  = bit_idx - 1'b1;
              mosi_n = word[bit_n];
            end
          end
        end
      end
      HOLD: begin
        if (!div_end) begin
          div_n = div + 1'b1;
        end else begin
          div_n   = '0;
          state_n = GAP;
          cs_n_n  = 1'b1;
          mosi_n  = 1'b0;
        end
      end
      GAP: begin
        if (!div_end) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          if (!ch) begin
            state_n = SHIFT;
            ch_n    = 1'b1;
            bit_n   = BIT_TOP;
            word_n  = {1'b1, 1'b1, smp2};
            cs_n_n  = 1'b0;
            mosi_n  = 1'b1;
          end else begin
            state_n     = IDLE;
            pair_done_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= 1'b0;
      div       <= '0;
      bit_idx   <= '0;
      word      <= '0;
      smp2      <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      pair_done <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      div       <= div_n;
      bit_idx   <= bit_n;
      word      <= word_n;
      smp2      <= smp2_n;
      cs_n      <= cs_n_n;
      sclk      <= sclk_n;
      mosi      <= mosi_n;
      pair_done <= pair_done_n;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default divider instance plus a
// CLK_DIV=1 instance, each observed by a small serial DAC receiver model.
module tb_dac_spi_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, valid = 1'b0;
  logic       en1 = 1'b0, valid1 = 1'b0;
  logic [7:0] sa = '0, sb = '0, sa1 = '0, sb1 = '0;
  logic       ready, cs_n, sclk, mosi, pair_done;
  logic       ready1, cs_n1, sclk1, mosi1, pair_done1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pd_cnt = 0;
  int acc_q[$];
  logic [15:0] frm_q[$], frm1_q[$];
  int fn_q[$], fn1_q[$];
  logic [15:0] m_sh = '0, m1_sh = '0;
  int m_n = 0, m1_n = 0;

  dac_spi_tx #(.D_WIDTH(8), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sample1(sa), .sample2(sb),
    .valid(valid), .ready(ready), .cs_n(cs_n), .sclk(sclk),
    .mosi(mosi), .pair_done(pair_done)
  );

  dac_spi_tx #(.D_WIDTH(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .sample1(sa1), .sample2(sb1),
    .valid(valid1), .ready(ready1), .cs_n(cs_n1), .sclk(sclk1),
    .mosi(mosi1), .pair_done(pair_done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (valid && ready && !rst) acc_q.push_back(cyc);
  always @(posedge clk) if (pair_done) pd_cnt <= pd_cnt + 1;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      frm_q.push_back(m_sh);
      fn_q.push_back(m_n);
      m_sh <= '0;
      m_n  <= 0;
    end else begin
      m_sh <= {m_sh[14:0], mosi};
      m_n  <= m_n + 1;
    end
  end

  always @(posedge sclk1 or posedge cs_n1) begin
    if (cs_n1) begin
      frm1_q.push_back(m1_sh);
      fn1_q.push_back(m1_n);
      m1_sh <= '0;
      m1_n  <= 0;
    end else begin
      m1_sh <= {m1_sh[14:0], mosi1};
      m1_n  <= m1_n + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; en1 = 1'b1; valid = 1'b0; valid1 = 1'b0;
    step(2);
    n_chk++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n got %b want 1", cs_n); end
    n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk got %b want 0", sclk); end
    n_chk++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got %b want 0", mosi); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", ready); end
    n_chk++; if (pair_done !== 1'b0) begin n_fail++; $display("FAIL rst_pair_done got %b want 0", pair_done); end
    n_chk++; if (cs_n1 !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n1 got %b want 1", cs_n1); end
    n_chk++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_ready1 got %b want 1", ready1); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single;
    int base, pd0;
    base = frm_q.size(); pd0 = pd_cnt;
    sa = 8'hA5; sb = 8'h3C; valid = 1'b1;
    step(1);
    valid = 1'b0; sa = '0; sb = '0;
    n_chk++; if (cs_n !== 1'b0) begin n_fail++; $display("FAIL single_t0_cs_n got %b want 0", cs_n); end
    n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL single_t0_sclk got %b want 0", sclk); end
    n_chk++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL single_t0_mosi got %b want 0", mosi); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL single_t0_ready got %b want 0", ready); end
    step(3);
    n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL single_t3_sclk got %b want 0", sclk); end
    step(1);
    n_chk++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL single_t4_sclk got %b want 1", sclk); end
    step(4);
    n_chk++; if (sclk !== 1'b0 || mosi !== 1'b1) begin n_fail++; $display("FAIL single_t8_sclk_mosi got %b%b want 01", sclk, mosi); end
    step(75);
    n_chk++; if (cs_n !== 1'b0) begin n_fail++; $display("FAIL single_t83_cs_n got %b want 0", cs_n); end
    step(1);
    n_chk++; if (cs_n !== 1'b1 || mosi !== 1'b0) begin n_fail++; $display("FAIL single_t84_gap got cs_n=%b mosi=%b want 1 0", cs_n, mosi); end
    step(4);
    n_chk++; if (cs_n !== 1'b0 || mosi !== 1'b1 || sclk !== 1'b0) begin n_fail++; $display("FAIL single_t88_ch1 got cs_n=%b mosi=%b sclk=%b want 0 1 0", cs_n, mosi, sclk); end
    step(87);
    n_chk++; if (pair_done !== 1'b0) begin n_fail++; $display("FAIL single_t175_pd got %b want 0", pair_done); end
    step(1);
    n_chk++; if (pair_done !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL single_t176_done got pd=%b ready=%b want 1 1", pair_done, ready); end
    step(1);
    n_chk++; if (pair_done !== 1'b0) begin n_fail++; $display("FAIL single_t177_pd got %b want 0", pair_done); end
    n_chk++; if (frm_q.size() - base !== 2) begin n_fail++; $display("FAIL single_nframes got %0d want 2", frm_q.size() - base); end
    n_chk++; if (frm_q[base] !== 16'h01A5 || fn_q[base] !== 10) begin n_fail++; $display("FAIL single_frame0 got %h/%0d want 01a5/10", frm_q[base], fn_q[base]); end
    n_chk++; if (frm_q[base+1] !== 16'h033C || fn_q[base+1] !== 10) begin n_fail++; $display("FAIL single_frame1 got %h/%0d want 033c/10", frm_q[base+1], fn_q[base+1]); end
    n_chk++; if (pd_cnt - pd0 !== 1) begin n_fail++; $display("FAIL single_pd_count got %0d want 1", pd_cnt - pd0); end
  endtask

  task automatic test_clkdiv1;
    int base;
    base = frm1_q.size();
    sa1 = 8'hFF; sb1 = 8'h00; valid1 = 1'b1;
    step(1);
    valid1 = 1'b0;
    n_chk++; if (cs_n1 !== 1'b0 || sclk1 !== 1'b0 || mosi1 !== 1'b0) begin n_fail++; $display("FAIL div1_t0 got cs_n=%b sclk=%b mosi=%b want 0 0 0", cs_n1, sclk1, mosi1); end
    step(1);
    n_chk++; if (sclk1 !== 1'b1) begin n_fail++; $display("FAIL div1_t1_sclk got %b want 1", sclk1); end
    step(1);
    n_chk++; if (sclk1 !== 1'b0 || mosi1 !== 1'b1) begin n_fail++; $display("FAIL div1_t2 got sclk=%b mosi=%b want 0 1", sclk1, mosi1); end
    step(18);
    n_chk++; if (cs_n1 !== 1'b0 || sclk1 !== 1'b0) begin n_fail++; $display("FAIL div1_t20_hold got cs_n=%b sclk=%b want 0 0", cs_n1, sclk1); end
    step(1);
    n_chk++; if (cs_n1 !== 1'b1) begin n_fail++; $display("FAIL div1_t21_gap got %b want 1", cs_n1); end
    step(1);
    n_chk++; if (cs_n1 !== 1'b0 || mosi1 !== 1'b1) begin n_fail++; $display("FAIL div1_t22_ch1 got cs_n=%b mosi=%b want 0 1", cs_n1, mosi1); end
    step(21);
    n_chk++; if (pair_done1 !== 1'b0) begin n_fail++; $display("FAIL div1_t43_pd got %b want 0", pair_done1); end
    step(1);
    n_chk++; if (pair_done1 !== 1'b1 || ready1 !== 1'b1) begin n_fail++; $display("FAIL div1_t44_done got pd=%b ready=%b want 1 1", pair_done1, ready1); end
    step(1);
    n_chk++; if (frm1_q.size() - base !== 2) begin n_fail++; $display("FAIL div1_nframes got %0d want 2", frm1_q.size() - base); end
    n_chk++; if (frm1_q[base] !== 16'h01FF || fn1_q[base] !== 10) begin n_fail++; $display("FAIL div1_frame0 got %h/%0d want 01ff/10", frm1_q[base], fn1_q[base]); end
    n_chk++; if (frm1_q[base+1] !== 16'h0300 || fn1_q[base+1] !== 10) begin n_fail++; $display("FAIL div1_frame1 got %h/%0d want 0300/10", frm1_q[base+1], fn1_q[base+1]); end
  endtask

  task automatic test_handshake;
    int base;
    base = frm_q.size();
    en = 1'b0; sa = 8'h11; sb = 8'h22; valid = 1'b1;
    step(1);
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_en0 got %b want 0", ready); end
    step(5);
    n_chk++; if (cs_n !== 1'b1 || frm_q.size() != base) begin n_fail++; $display("FAIL hs_no_start got cs_n=%b frames=%0d want 1 0", cs_n, frm_q.size() - base); end
    en = 1'b1;
    #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_en1 got %b want 1", ready); end
    step(1);
    valid = 1'b0; en = 1'b0;
    step(10);
    sa = 8'hEE; sb = 8'hDD;
    step(166);
    n_chk++; if (pair_done !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL hs_done_en0 got pd=%b ready=%b want 1 0", pair_done, ready); end
    step(1);
    en = 1'b1;
    n_chk++; if (frm_q.size() - base !== 2) begin n_fail++; $display("FAIL hs_nframes got %0d want 2", frm_q.size() - base); end
    n_chk++; if (frm_q[base] !== 16'h0111) begin n_fail++; $display("FAIL hs_frame0 got %h want 0111", frm_q[base]); end
    n_chk++; if (frm_q[base+1] !== 16'h0322) begin n_fail++; $display("FAIL hs_frame1 got %h want 0322", frm_q[base+1]); end
  endtask

  task automatic test_reset_mid;
    int base, pd0;
    sa = 8'h5A; sb = 8'hC3; valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(29);
    rst = 1'b1; pd0 = pd_cnt;
    step(1);
    n_chk++; if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin n_fail++; $display("FAIL rmid_abort got cs_n=%b sclk=%b mosi=%b want 1 0 0", cs_n, sclk, mosi); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", ready); end
    rst = 1'b0;
    step(200);
    n_chk++; if (pd_cnt !== pd0 || cs_n !== 1'b1) begin n_fail++; $display("FAIL rmid_no_done got pd=%0d cs_n=%b want 0 1", pd_cnt - pd0, cs_n); end
    base = frm_q.size();
    sa = 8'h66; sb = 8'h99; valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(177);
    n_chk++; if (frm_q.size() - base !== 2) begin n_fail++; $display("FAIL rmid_nframes got %0d want 2", frm_q.size() - base); end
    n_chk++; if (frm_q[base] !== 16'h0166 || frm_q[base+1] !== 16'h0399) begin n_fail++; $display("FAIL rmid_frames got %h %h want 0166 0399", frm_q[base], frm_q[base+1]); end
  endtask

  task automatic test_back_to_back;
    int base, abase, pd0, n;
    logic [15:0] exp_f[6];
    exp_f = '{16'h0101, 16'h0381, 16'h0102, 16'h0382, 16'h0103, 16'h0383};
    base = frm_q.size(); abase = acc_q.size(); pd0 = pd_cnt;
    sa = 8'h01; sb = 8'h81; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ready && n < 400) begin step(1); n++; end
      n_chk++; if (!ready) begin n_fail++; $display("FAIL b2b_wait_ready pair %0d timed out", i); end
      step(1);
      sa = 8'(i + 2); sb = 8'(8'h82 + i);
      if (i == 2) valid = 1'b0;
    end
    step(180);
    n_chk++; if (acc_q.size() - abase !== 3) begin n_fail++; $display("FAIL b2b_naccepts got %0d want 3", acc_q.size() - abase); end
    for (int i = 1; i < 3; i++) begin
      n_chk++; if (acc_q[abase+i] - acc_q[abase+i-1] !== 177) begin n_fail++; $display("FAIL b2b_period %0d got %0d want 177", i, acc_q[abase+i] - acc_q[abase+i-1]); end
    end
    n_chk++; if (frm_q.size() - base !== 6) begin n_fail++; $display("FAIL b2b_nframes got %0d want 6", frm_q.size() - base); end
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (frm_q[base+i] !== exp_f[i]) begin n_fail++; $display("FAIL b2b_frame%0d got %h want %h", i, frm_q[base+i], exp_f[i]); end
    end
    n_chk++; if (pd_cnt - pd0 !== 3) begin n_fail++; $display("FAIL b2b_pd_count got %0d want 3", pd_cnt - pd0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_clkdiv1;
    test_handshake;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
